// File: rtl/table_read_master.sv
// table_read_master: Avalon-MM read master that streams a contiguous block of
// words from a latency-1 on-chip RAM slave out as a valid/ready stream.
// A credit check against a small output FIFO means a returned read word
// always has a free slot, so no data is ever dropped under sink backpressure.
module table_read_master #(
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     length,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_chipselect,
    output logic                avm_write,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic                avm_clken,
    input  logic [DATA_W-1:0]   avm_readdata,
    output logic [DATA_W-1:0]   st_data,
    output logic                st_valid,
    input  logic                st_ready,
    output logic                st_last
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CRD_W = PTR_W + 2;
    localparam int unsigned LEN_W = ADDR_W + 1;

    localparam logic [LEN_W-1:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CRD_W-1:0] DEPTH_X = CRD_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_rem;
    logic              r_cs;
    logic              r_inflight;
    logic              r_inflight_last;
    logic              r_done;

    logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
    logic              r_mem_last [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;

    logic [LEN_W-1:0]  w_len_sat;
    logic              w_valid;
    logic              w_pop;
    logic              w_push;
    logic              w_last_hs;
    logic              w_flush;
    logic              w_busy;
    logic [LEN_W-1:0]  w_rem_next;
    logic [CNT_W-1:0]  w_count_next;
    logic [CRD_W-1:0]  w_credit;
    logic              w_cs_next;
    logic              w_done_next;

    // Handshake and command qualifiers shared by the FSM and datapath
    always_comb begin
        w_len_sat = (length > LEN_MAX) ? LEN_MAX : length;
        w_valid   = (r_count != '0);
        w_pop     = w_valid & st_ready;
        w_push    = r_inflight;
        w_last_hs = w_pop & r_mem_last[r_rptr];
        w_flush   = abort & (r_state != IDLE);
    end

    // Words still to be issued: loaded on start, counted down per issue
    always_comb begin
        w_rem_next = r_rem;
        if (r_state == IDLE) begin
            if (start) begin
                w_rem_next = w_len_sat;
            end
        end else if (r_cs) begin
            w_rem_next = r_rem - LEN_W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; abort wins over a same-cycle final handshake
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start && (w_len_sat != '0)) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    w_state_next = IDLE;
                end else if (w_rem_next == '0) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (abort || w_last_hs) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_busy = (r_state != IDLE);
    end

    // Chipselect is registered, so the credit test is evaluated on the
    // occupancy the next cycle will see: FIFO count after this cycle's
    // push/pop plus the read issued this cycle, which is in flight then.
    always_comb begin
        w_count_next = r_count;
        if (w_flush) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CNT_W'(1);
        end
        w_credit    = {1'b0, w_count_next} + CRD_W'(r_cs);
        w_cs_next   = (w_state_next == RUN) && (w_rem_next != '0) && (w_credit < DEPTH_X);
        w_done_next = ((r_state == IDLE) && start && (w_len_sat == '0)) ||
                      ((r_state == DRAIN) && !abort && w_last_hs);
    end

    // Read issue, in-flight tracking, address walk and FIFO pointers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr          <= '0;
            r_rem           <= '0;
            r_cs            <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
            r_count         <= '0;
            r_wptr          <= '0;
            r_rptr          <= '0;
        end else begin
            r_rem           <= w_rem_next;
            r_cs            <= w_cs_next;
            r_inflight      <= r_cs & ~w_flush;
            r_inflight_last <= r_cs & (r_rem == LEN_W'(1));
            r_done          <= w_done_next;
            r_count         <= w_count_next;
            if ((r_state == IDLE) && start && (w_len_sat != '0)) begin
                r_addr <= base_addr;
            end else if (r_cs) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
            if (w_flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PTR_W'(1);
                end
            end
        end
    end

    // FIFO storage: returned word and its last-of-transfer tag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_last[i] <= 1'b0;
            end
        end else if (w_push) begin
            r_mem_data[r_wptr] <= avm_readdata;
            r_mem_last[r_wptr] <= r_inflight_last;
        end
    end

    assign busy           = w_busy;
    assign done           = r_done;
    assign avm_address    = r_addr;
    assign avm_chipselect = r_cs;
    assign avm_write      = 1'b0;
    assign avm_byteenable = '1;
    assign avm_clken      = 1'b1;
    assign st_data        = r_mem_data[r_rptr];
    assign st_valid       = w_valid;
    assign st_last        = w_valid & r_mem_last[r_rptr];

endmodule

// File: tb/tb_table_read_master.sv
// Directed bench for table_read_master with a latency-1 RAM model holding
// mem[i] = i*3 and a negedge monitor that logs reads, handshakes and done.
module tb_table_read_master;

    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned FIFO_DEPTH = 4;

    logic                clk       = 1'b0;
    logic                reset_n   = 1'b0;
    logic                start     = 1'b0;
    logic [ADDR_W-1:0]   base_addr = '0;
    logic [ADDR_W:0]     length    = '0;
    logic                abort     = 1'b0;
    logic                st_ready  = 1'b0;
    logic                busy;
    logic                done;
    logic [ADDR_W-1:0]   avm_address;
    logic                avm_chipselect;
    logic                avm_write;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic                avm_clken;
    logic [DATA_W-1:0]   avm_readdata = '0;
    logic [DATA_W-1:0]   st_data;
    logic                st_valid;
    logic                st_last;

    table_read_master #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .base_addr     (base_addr),
        .length        (length),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .avm_address   (avm_address),
        .avm_chipselect(avm_chipselect),
        .avm_write     (avm_write),
        .avm_byteenable(avm_byteenable),
        .avm_clken     (avm_clken),
        .avm_readdata  (avm_readdata),
        .st_data       (st_data),
        .st_valid      (st_valid),
        .st_ready      (st_ready),
        .st_last       (st_last)
    );

    always #5 clk = ~clk;

    // RAM slave model: data for the requested word appears the next cycle
    always @(posedge clk) begin
        if (avm_chipselect) avm_readdata <= 16'(32'(avm_address) * 3);
    end

    int n_err = 0;
    int n_chk = 0;

    int cyc = 0, start_cyc = 0, done_cnt = 0, done_cyc = 0;
    int cs_cnt = 0, valid_cnt = 0, stab_err = 0, max_out = 0;
    logic [DATA_W-1:0] data_q[$];
    logic              last_q[$];
    int                hs_cyc_q[$];
    logic [ADDR_W-1:0] addr_q[$];
    logic              p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0;
    logic [DATA_W-1:0] p_data = '0;

    // Per-cycle monitor, sampled mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (start) start_cyc = cyc;
        if (st_valid) valid_cnt++;
        if (avm_chipselect) begin
            cs_cnt++;
            addr_q.push_back(avm_address);
        end
        if (cs_cnt - data_q.size() > max_out) max_out = cs_cnt - data_q.size();
        if (p_valid && !p_ready && st_valid && (st_data !== p_data || st_last !== p_last)) stab_err++;
        if (st_valid && st_ready) begin
            data_q.push_back(st_data);
            last_q.push_back(st_last);
            hs_cyc_q.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        p_valid = st_valid;
        p_ready = st_ready;
        p_data  = st_data;
        p_last  = st_last;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        data_q.delete();
        last_q.delete();
        hs_cyc_q.delete();
        addr_q.delete();
        done_cnt  = 0;
        cs_cnt    = 0;
        valid_cnt = 0;
        stab_err  = 0;
        max_out   = 0;
    endtask

    task automatic do_start(input int base, input int len);
        base_addr = ADDR_W'(base);
        length    = (ADDR_W+1)'(len);
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
    endtask

    // Wait for done (bounded); toggle selects the 1,0,0 ready pattern
    task automatic wait_done(input int budget, input bit toggle);
        for (int i = 0; i < budget && done_cnt == 0; i++) begin
            st_ready = toggle ? (i % 3 == 0) : 1'b1;
            tick(1);
        end
        st_ready = 1'b1;
        tick(3);
    endtask

    function automatic logic [31:0] q_data(input int i);
        return (i < data_q.size()) ? 32'(data_q[i]) : 'x;
    endfunction

    function automatic logic [31:0] q_last(input int i);
        return (i < last_q.size()) ? 32'(last_q[i]) : 'x;
    endfunction

    function automatic logic [31:0] q_addr(input int i);
        return (i < addr_q.size()) ? 32'(addr_q[i]) : 'x;
    endfunction

    function automatic int last_hs_cyc();
        return (hs_cyc_q.size() > 0) ? hs_cyc_q[hs_cyc_q.size()-1] : -1;
    endfunction

    task automatic check_stream(input string tag, input int n, input int base);
        check({tag, "_words"}, data_q.size(), n);
        check({tag, "_reads"}, cs_cnt, n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), q_addr(i), (base + i) % 128);
            check($sformatf("%s_data%0d", tag, i), q_data(i), ((base + i) % 128) * 3);
            check($sformatf("%s_last%0d", tag, i), q_last(i), (i == n - 1) ? 1 : 0);
        end
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_cyc"}, done_cyc, last_hs_cyc() + 1);
        check({tag, "_busy_end"}, busy, 0);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cs", avm_chipselect, 0);
        check("rst_addr", avm_address, 0);
        check("rst_valid", st_valid, 0);
        check("rst_last", st_last, 0);
        check("rst_data", st_data, 0);
        check("const_write", avm_write, 0);
        check("const_be", avm_byteenable, 3);
        check("const_clken", avm_clken, 1);
        reset_n = 1'b1;
        tick(2);

        // Basic: base 5, length 4, sink always ready
        clear_mon();
        st_ready = 1'b1;
        do_start(5, 4);
        check("t1_busy_t1", busy, 1);
        check("t1_cs_t1", avm_chipselect, 1);
        check("t1_addr_t1", avm_address, 5);
        wait_done(50, 1'b0);
        check_stream("t1", 4, 5);
        check("t1_first_lat", (hs_cyc_q.size() > 0) ? hs_cyc_q[0] - start_cyc : -1, 3);
        check("t1_back2back", (hs_cyc_q.size() == 4) ? hs_cyc_q[3] - hs_cyc_q[0] : -1, 3);

        // Address wrap 126,127,0,1
        clear_mon();
        do_start(126, 4);
        wait_done(50, 1'b0);
        check_stream("t2", 4, 126);

        // Backpressure with ready pattern 1,0,0
        clear_mon();
        do_start(10, 10);
        wait_done(300, 1'b1);
        check_stream("t3", 10, 10);
        check("t3_max_outstanding", max_out, FIFO_DEPTH);
        check("t3_stable", stab_err, 0);

        // length 0: done next cycle, nothing issued
        clear_mon();
        do_start(7, 0);
        check("t4_done", done, 1);
        check("t4_busy", busy, 0);
        tick(1);
        check("t4_done_pulse", done, 0);
        tick(3);
        check("t4_reads", cs_cnt, 0);
        check("t4_valid", valid_cnt, 0);
        check("t4_done_cnt", done_cnt, 1);

        // Saturation: 300 does not fit the 8-bit length port; 200 > 128 saturates
        clear_mon();
        do_start(0, 200);
        wait_done(400, 1'b0);
        check_stream("t5", 128, 0);

        // Abort two cycles into a length-20 transfer
        clear_mon();
        do_start(0, 20);
        tick(1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("t6_cs_off", avm_chipselect, 0);
        check("t6_valid_off", st_valid, 0);
        check("t6_busy_off", busy, 0);
        tick(5);
        check("t6_no_done", done_cnt, 0);
        check("t6_reads", cs_cnt, 2);
        check("t6_no_words", valid_cnt, 0);
        clear_mon();
        do_start(0, 2);
        wait_done(50, 1'b0);
        check_stream("t6b", 2, 0);

        // start while busy is ignored
        clear_mon();
        do_start(20, 6);
        tick(1);
        base_addr = 7'd50;
        length    = 8'd3;
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
        wait_done(50, 1'b0);
        check_stream("t7", 6, 20);

        // abort in IDLE is ignored
        clear_mon();
        abort = 1'b1;
        tick(2);
        abort = 1'b0;
        tick(1);
        check("t8_busy", busy, 0);
        check("t8_done", done_cnt, 0);
        check("t8_reads", cs_cnt, 0);

        // Asynchronous reset mid-transfer
        clear_mon();
        do_start(0, 20);
        tick(3);
        #2;
        reset_n = 1'b0;
        #1;
        check("t9_busy", busy, 0);
        check("t9_done", done, 0);
        check("t9_cs", avm_chipselect, 0);
        check("t9_addr", avm_address, 0);
        check("t9_valid", st_valid, 0);
        check("t9_last", st_last, 0);
        check("t9_data", st_data, 0);
        reset_n = 1'b1;
        tick(2);
        check("t9_idle_busy", busy, 0);
        check("t9_idle_cs", avm_chipselect, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
